// File: rtl/sc_et_pkg.sv
// Shared types and helpers for the stochastic-computing early-termination counter.
package sc_et_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] k;
  } cp_t;

  // Flags a stream length of 2^k with k_min <= k <= w and returns k.
  function automatic cp_t is_checkpoint(input logic [31:0] len, input int w, input int k_min);
    cp_t r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      if (k >= k_min && k <= w && len == (32'd1 << k)) begin
        r.valid = 1'b1;
        r.k     = 8'(k);
      end
    end
    return r;
  endfunction

  // Ones count after 2^k bits, rescaled so that 2^w means 1.0.
  function automatic logic [31:0] scale_est(input logic [31:0] cnt, input int k, input int w);
    return cnt << (w - k);
  endfunction

endpackage

// File: rtl/sc_et_compare.sv
// Closeness test between two consecutive checkpoint estimates.
module sc_et_compare #(
  parameter int W         = 8,
  parameter int ET_THRESH = 1
) (
  input  logic [W:0] i_a,
  input  logic [W:0] i_b,
  output logic       o_close
);

  logic [W+1:0] w_a, w_b, w_diff;

  // One guard bit so the unsigned difference can never wrap.
  always_comb begin
    w_a     = {1'b0, i_a};
    w_b     = {1'b0, i_b};
    w_diff  = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    o_close = (w_diff <= (W+2)'(ET_THRESH));
  end

endmodule

// File: rtl/sc_et_counter.sv
// Unipolar bitstream accumulator with power-of-two checkpoints and early stop.
module sc_et_counter
  import sc_et_pkg::*;
#(
  parameter int W         = 8,
  parameter int K_MIN     = 4,
  parameter int ET_THRESH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         et_en,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result,
  output logic [W:0]   len_out,
  output logic         et_flag
);

  state_t     r_state, w_state_nxt;
  logic [W:0] r_cnt, r_len, r_prev, r_result, r_len_out;
  logic       r_have_prev, r_et_en, r_et_flag;

  logic [W:0] w_cnt_nxt, w_len_nxt, w_est;
  cp_t        w_cp;
  logic       w_accept, w_close, w_full, w_early, w_term;

  sc_et_compare #(.W(W), .ET_THRESH(ET_THRESH)) u_cmp (
    .i_a     (w_est),
    .i_b     (r_prev),
    .o_close (w_close)
  );

  // Speculative next counts and checkpoint decision for the bit on the input.
  always_comb begin
    w_accept  = (r_state == S_RUN) && bit_valid && !start;
    w_cnt_nxt = r_cnt + (W+1)'(bit_in);
    w_len_nxt = r_len + (W+1)'(1);
    w_cp      = is_checkpoint(32'(w_len_nxt), W, K_MIN);
    w_est     = (W+1)'(scale_est(32'(w_cnt_nxt), int'(w_cp.k), W));
    w_full    = w_cp.valid && (int'(w_cp.k) == W);
    w_early   = w_cp.valid && r_have_prev && r_et_en && w_close;
    w_term    = w_accept && (w_full || w_early);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: start wins over everything, a terminating bit ends RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = S_RUN;
    else if (r_state == S_RUN && w_term)
      w_state_nxt = S_DONE;
  end

  // Accumulators, previous estimate and captured results.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_result    <= '0;
      r_len_out   <= '0;
      r_et_flag   <= 1'b0;
      r_et_en     <= rst ? 1'b0 : et_en;
    end else if (w_accept) begin
      r_cnt <= w_cnt_nxt;
      r_len <= w_len_nxt;
      if (w_term) begin
        r_result  <= w_est;
        r_len_out <= w_len_nxt;
        // Reaching full length is never reported as an early stop.
        r_et_flag <= w_early && !w_full;
      end else if (w_cp.valid) begin
        r_prev      <= w_est;
        r_have_prev <= 1'b1;
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign result  = r_result;
  assign len_out = r_len_out;
  assign et_flag = r_et_flag;

endmodule

// File: tb/tb_sc_et_counter.sv
// Bench for sc_et_counter: directed scenarios plus random streams vs. a stream-level model.
module tb_sc_et_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         et_en = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         busy, done, et_flag;
  logic [W:0]   result, len_out;

  int checks = 0;
  int fails  = 0;
  bit stim [256];

  sc_et_counter #(.W(W), .K_MIN(4), .ET_THRESH(1)) dut (
    .clk(clk), .rst(rst), .start(start), .et_en(et_en), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy), .done(done), .result(result),
    .len_out(len_out), .et_flag(et_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reads the stream as a whole: running ones fraction at each power-of-two
  // length from 16 on, stop when two successive fractions agree within 1/256.
  task automatic model(input bit en, output int res, output int len, output int flag);
    int cnt, prev, est, d;
    bit have;
    cnt = 0; prev = 0; have = 0;
    res = 0; len = 0; flag = 0;
    for (int n = 1; n <= 256; n++) begin
      cnt += int'(stim[n-1]);
      if (n >= 16 && (n & (n - 1)) == 0) begin
        est = cnt * 256 / n;
        d = (est > prev) ? est - prev : prev - est;
        if (n == 256) begin
          res = est; len = 256; flag = 0; return;
        end
        if (have && en && d <= 1) begin
          res = est; len = n; flag = 1; return;
        end
        prev = est;
        have = 1;
      end
    end
  endtask

  task automatic do_start(input bit en);
    start = 1'b1; et_en = en;
    bit_valid = 1'b1; bit_in = 1'b1;   // bit alongside start must be dropped
    tick();
    start = 1'b0; et_en = 1'b0; bit_valid = 1'b0;
  endtask

  // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random gaps.
  task automatic run(input string tag, input bit en, input int gap, output int busy_vld);
    int er, el, ef, idx, cyc;
    bit vld, last_vld;
    model(en, er, el, ef);
    do_start(en);
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    idx = 0; cyc = 0; busy_vld = 0; last_vld = 0;
    while (!done && cyc < 1200) begin
      vld = (gap == 0) ? 1'b1 : (gap == 1) ? bit'(cyc % 2) : ($urandom_range(0, 2) != 0);
      bit_valid = vld;
      bit_in = stim[idx % 256];
      if (vld && busy) busy_vld++;
      tick();
      if (vld) idx++;
      last_vld = vld;
      cyc++;
      if (busy && done) chk({tag, "_busy_and_done"}, 32'd1, 32'd0);
    end
    bit_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_len_out"}, 32'(len_out), 32'(el));
    chk({tag, "_et_flag"}, 32'(et_flag), 32'(ef));
    chk({tag, "_bits_fed"}, 32'(idx), 32'(el));
    chk({tag, "_latency"}, 32'(last_vld), 32'd1);
    // DONE ignores further bits and holds its outputs
    bit_valid = 1'b1; bit_in = 1'b1;
    tick(); tick();
    bit_valid = 1'b0;
    chk({tag, "_hold_result"}, 32'(result), 32'(er));
    chk({tag, "_hold_len"}, 32'(len_out), 32'(el));
    chk({tag, "_hold_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int bv, p;
    bit en;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_len", 32'(len_out), 32'd0);
    chk("rst_flag", 32'(et_flag), 32'd0);
    rst = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("idle_ignores_bits", 32'(busy), 32'd0);

    for (int i = 0; i < 256; i++) stim[i] = 1'b0;
    run("zeros", 1'b1, 0, bv);
    chk("zeros_exp_len", 32'(len_out), 32'd32);
    chk("zeros_exp_flag", 32'(et_flag), 32'd1);

    for (int i = 0; i < 256; i++) stim[i] = 1'b1;
    run("ones", 1'b0, 0, bv);
    chk("ones_exp_result", 32'(result), 32'd256);
    chk("ones_busy_cycles", 32'(bv), 32'd256);

    for (int i = 0; i < 256; i++) stim[i] = (i % 2 == 0);
    run("alt", 1'b1, 0, bv);
    chk("alt_exp_result", 32'(result), 32'd128);
    chk("alt_exp_len", 32'(len_out), 32'd32);
    run("alt_gap", 1'b1, 1, bv);

    // restart mid-run after 10 ones, then an all-zero stream
    for (int i = 0; i < 256; i++) stim[i] = 1'b1;
    do_start(1'b1);
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1; tick();
    end
    bit_valid = 1'b0;
    for (int i = 0; i < 256; i++) stim[i] = 1'b0;
    run("restart", 1'b1, 0, bv);
    chk("restart_len", 32'(len_out), 32'd32);

    // start on the same cycle as the terminating bit
    for (int i = 0; i < 256; i++) stim[i] = (i % 2 == 0);
    do_start(1'b1);
    for (int i = 0; i < 31; i++) begin
      bit_valid = 1'b1; bit_in = stim[i]; tick();
    end
    start = 1'b1; et_en = 1'b1; bit_valid = 1'b1; bit_in = stim[31];
    tick();
    start = 1'b0;
    chk("collide_busy", 32'(busy), 32'd1);
    chk("collide_done", 32'(done), 32'd0);
    chk("collide_result", 32'(result), 32'd0);
    for (int i = 0; i < 32; i++) begin
      bit_valid = 1'b1; bit_in = stim[i]; tick();
    end
    bit_valid = 1'b0;
    chk("collide_rerun_done", 32'(done), 32'd1);
    chk("collide_rerun_result", 32'(result), 32'd128);
    chk("collide_rerun_len", 32'(len_out), 32'd32);

    // rst at len=20, with a simultaneous start that must lose
    for (int i = 0; i < 256; i++) stim[i] = 1'b1;
    do_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1; tick();
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
    chk("rst_run_busy", 32'(busy), 32'd0);
    chk("rst_run_done", 32'(done), 32'd0);
    chk("rst_run_result", 32'(result), 32'd0);
    chk("rst_run_len", 32'(len_out), 32'd0);
    chk("rst_run_flag", 32'(et_flag), 32'd0);

    // random streams with random density, enable and gap pattern
    for (int r = 0; r < 8; r++) begin
      p  = $urandom_range(0, 100);
      en = bit'($urandom_range(0, 1));
      for (int i = 0; i < 256; i++) stim[i] = ($urandom_range(0, 99) < p);
      run($sformatf("rnd%0d", r), en, $urandom_range(0, 2), bv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
